// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU control path: opcodes, FSM states,
// instruction classes, flag bit positions and instruction field positions.
package cpu19_pkg;

   // Instruction field positions
   localparam int OPC_MSB   = 18;
   localparam int OPC_LSB   = 14;
   localparam int RD_MSB    = 13;
   localparam int RD_LSB    = 10;
   localparam int RS1_MSB   = 9;
   localparam int RS1_LSB   = 6;
   localparam int RS2_MSB   = 5;
   localparam int RS2_LSB   = 2;
   localparam int ADDR_MSB  = 9;
   localparam int SHORT_MSB = 5;

   // Flag bit indices
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   // Opcodes
   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_MUL = 5'b00010;
   localparam logic [4:0] OP_DIV = 5'b00011;
   localparam logic [4:0] OP_INC = 5'b00100;
   localparam logic [4:0] OP_DEC = 5'b00101;
   localparam logic [4:0] OP_AND = 5'b00110;
   localparam logic [4:0] OP_OR  = 5'b00111;
   localparam logic [4:0] OP_XOR = 5'b01000;
   localparam logic [4:0] OP_NOT = 5'b01001;
   localparam logic [4:0] OP_JMP = 5'b01010;
   localparam logic [4:0] OP_BEQ = 5'b01011;
   localparam logic [4:0] OP_BNE = 5'b01100;
   localparam logic [4:0] OP_LD  = 5'b01111;
   localparam logic [4:0] OP_ST  = 5'b10000;
   localparam logic [4:0] OP_CMP = 5'b10001;
   localparam logic [4:0] OP_HLT = 5'b11111;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_EXEC  = 3'd1,
      ST_MEM   = 3'd2,
      ST_WB    = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU = 3'd0,
      CL_CMP = 3'd1,
      CL_JMP = 3'd2,
      CL_BR  = 3'd3,
      CL_LD  = 3'd4,
      CL_ST  = 3'd5,
      CL_HLT = 3'd6,
      CL_ILL = 3'd7
   } opclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: groups each opcode into the instruction class that
// decides which FSM path it takes.
module ctrl_decode
   import cpu19_pkg::*;
(
   input  logic [4:0] opcode,
   output opclass_t   opclass
);

   // Pure lookup from opcode to class; anything unlisted is illegal
   always_comb begin
      opclass = CL_ILL;
      case (opcode)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC,
         OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT: opclass = CL_ALU;
         OP_CMP:                                 opclass = CL_CMP;
         OP_JMP:                                 opclass = CL_JMP;
         OP_BEQ, OP_BNE:                         opclass = CL_BR;
         OP_LD:                                  opclass = CL_LD;
         OP_ST:                                  opclass = CL_ST;
         OP_HLT:                                 opclass = CL_HLT;
         default:                                opclass = CL_ILL;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 19-bit CPU. Sequences each instruction
// through FETCH/EXEC/MEM/WB, holds the instruction and flag registers, and
// drives all datapath selects and enables from the state and latched IR.
module control_fsm
   import cpu19_pkg::*;
#(
   parameter int INSTR_W = 19,
   parameter int OPC_W   = 5,
   parameter int ALU_W   = 5,
   parameter int FLAG_W  = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic [FLAG_W-1:0]  Flag,
   output logic              pc_en,
   output logic              PCSrc,
   output logic              JMP,
   output logic              RegC,
   output logic              SBSC,
   output logic              RegWE,
   output logic [ALU_W-1:0]  ALUctrl,
   output logic              CWE,
   output logic              MemWE,
   output logic              DC,
   output logic              DLDM,
   output logic              halted,
   output logic              illegal,
   output logic [FLAG_W-1:0] flags_q
);

   state_t              state;
   logic [INSTR_W-1:0]  ir_q;
   logic [OPC_W-1:0]    opc;
   opclass_t            opclass;

   // Operand fields are consumed by the datapath directly from instr; only
   // the opcode of the latched IR matters here.
   logic                unused_ir;

   assign opc       = ir_q[OPC_MSB:OPC_LSB];
   assign unused_ir = ^ir_q[OPC_LSB-1:0];

   ctrl_decode u_decode (
      .opcode  (opc),
      .opclass (opclass)
   );

   // State sequencing plus IR, flag and halt registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_FETCH;
         ir_q    <= '0;
         flags_q <= '0;
         halted  <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               ir_q <= instr;
               // HLT is caught on the live instruction so it never reaches EXEC
               if (instr[OPC_MSB:OPC_LSB] == OP_HLT) begin
                  state  <= ST_HALT;
                  halted <= 1'b1;
               end else begin
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (opclass == CL_ALU || opclass == CL_CMP)
                  flags_q <= Flag;
               case (opclass)
                  CL_ALU:        state <= ST_WB;
                  CL_LD, CL_ST:  state <= ST_MEM;
                  default:       state <= ST_FETCH;
               endcase
            end
            ST_MEM: begin
               state <= (opclass == CL_LD) ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
               state <= ST_FETCH;
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

   // Control outputs decoded from state and latched opcode class
   always_comb begin
      pc_en   = 1'b0;
      PCSrc   = 1'b0;
      JMP     = 1'b0;
      RegC    = 1'b0;
      SBSC    = 1'b0;
      RegWE   = 1'b0;
      ALUctrl = '0;
      CWE     = 1'b0;
      MemWE   = 1'b0;
      DC      = 1'b0;
      DLDM    = 1'b0;
      illegal = 1'b0;
      case (state)
         ST_EXEC: begin
            case (opclass)
               CL_ALU: begin
                  ALUctrl = ALU_W'(opc);
               end
               CL_CMP: begin
                  ALUctrl = ALU_W'(OP_SUB);
                  pc_en   = 1'b1;
               end
               CL_JMP: begin
                  PCSrc = 1'b1;
                  JMP   = 1'b1;
                  pc_en = 1'b1;
               end
               CL_BR: begin
                  // Branches test the flags latched by the last ALU op/CMP
                  PCSrc = (opc == OP_BEQ) ? flags_q[FLAG_Z] : !flags_q[FLAG_Z];
                  pc_en = 1'b1;
               end
               CL_ST: begin
                  SBSC = 1'b1;
               end
               CL_ILL: begin
                  illegal = 1'b1;
                  pc_en   = 1'b1;
               end
               default: begin
               end
            endcase
         end
         ST_MEM: begin
            if (opclass == CL_ST) begin
               SBSC  = 1'b1;
               MemWE = 1'b1;
               pc_en = 1'b1;
            end
         end
         ST_WB: begin
            RegWE = 1'b1;
            pc_en = 1'b1;
            if (opclass == CL_LD)
               DLDM = 1'b1;
            else
               ALUctrl = ALU_W'(opc);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm: per-cycle expected output vectors are pushed to
// a scoreboard as stimulus is driven and compared on the falling edge.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] instr;
  logic [3:0]  Flag;
  logic        pc_en, PCSrc, JMP, RegC, SBSC, RegWE, CWE, MemWE, DC, DLDM;
  logic        halted, illegal;
  logic [4:0]  ALUctrl;
  logic [3:0]  flags_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .Flag    (Flag),
    .pc_en   (pc_en),
    .PCSrc   (PCSrc),
    .JMP     (JMP),
    .RegC    (RegC),
    .SBSC    (SBSC),
    .RegWE   (RegWE),
    .ALUctrl (ALUctrl),
    .CWE     (CWE),
    .MemWE   (MemWE),
    .DC      (DC),
    .DLDM    (DLDM),
    .halted  (halted),
    .illegal (illegal),
    .flags_q (flags_q)
  );

  // Observed output word:
  // [20]pc_en [19]PCSrc [18]JMP [17]RegC [16]SBSC [15]RegWE [14:10]ALUctrl
  // [9]CWE [8]MemWE [7]DC [6]DLDM [5]halted [4]illegal [3:0]flags_q
  logic [20:0] obs;
  assign obs = {pc_en, PCSrc, JMP, RegC, SBSC, RegWE, ALUctrl,
                CWE, MemWE, DC, DLDM, halted, illegal, flags_q};

  localparam logic [20:0] M_PE = 21'h100000;
  localparam logic [20:0] M_PS = 21'h080000;
  localparam logic [20:0] M_JM = 21'h040000;
  localparam logic [20:0] M_SB = 21'h010000;
  localparam logic [20:0] M_WE = 21'h008000;
  localparam logic [20:0] M_MW = 21'h000100;
  localparam logic [20:0] M_DL = 21'h000040;
  localparam logic [20:0] M_HA = 21'h000020;
  localparam logic [20:0] M_IL = 21'h000010;

  function automatic logic [20:0] al(input logic [4:0] v);
    return {6'b0, v, 10'b0};
  endfunction

  function automatic logic [20:0] fq(input logic [3:0] v);
    return {17'b0, v};
  endfunction

  typedef struct {
    string       name;
    int          cyc;
    logic [20:0] exp;
  } sb_t;

  sb_t sb[$];

  typedef struct {
    string            name;
    logic [18:0]      instr;
    logic [3:0]       flag;
    int               ncyc;
    logic [3:0][20:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input string n, input logic [18:0] i, input logic [3:0] f,
                               input int nc, input logic [20:0] e0, input logic [20:0] e1,
                               input logic [20:0] e2, input logic [20:0] e3);
    vec_t v;
    v.name  = n;
    v.instr = i;
    v.flag  = f;
    v.ncyc  = nc;
    v.exp   = {e3, e2, e1, e0};
    return v;
  endfunction

  // Scoreboard consumer: compare DUT outputs mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s cyc%0d: got %h expected %h", e.name, e.cyc, obs, e.exp);
      end
    end
  end

  // Queue one cycle's expectation and advance to just after the next rising edge
  task automatic step(input logic [20:0] e, input string n, input int c);
    sb_t s;
    s.name = n;
    s.cyc  = c;
    s.exp  = e;
    sb.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    instr = v.instr;
    Flag  = v.flag;
    for (int c = 0; c < v.ncyc; c++)
      step(v.exp[c], v.name, c);
  endtask

  localparam logic [18:0] I_ADD  = {5'b00000, 4'd3, 4'd1, 4'd2, 2'b00};
  localparam logic [18:0] I_MUL  = {5'b00010, 4'd5, 4'd6, 4'd7, 2'b00};
  localparam logic [18:0] I_CMP  = {5'b10001, 4'd0, 4'd1, 4'd2, 2'b00};
  localparam logic [18:0] I_BEQ  = {5'b01011, 8'h00, 6'h2A};
  localparam logic [18:0] I_BNE  = {5'b01100, 8'h00, 6'h15};
  localparam logic [18:0] I_JMP  = {5'b01010, 4'd0, 10'h3FF};
  localparam logic [18:0] I_LD   = {5'b01111, 4'd4, 10'h155};
  localparam logic [18:0] I_ST   = {5'b10000, 4'd4, 10'h155};
  localparam logic [18:0] I_XOR  = {5'b01000, 4'd2, 4'd3, 4'd4, 2'b00};
  localparam logic [18:0] I_NOT  = {5'b01001, 4'd2, 4'd3, 4'd0, 2'b00};
  localparam logic [18:0] I_IL1  = {5'b10101, 14'h0};
  localparam logic [18:0] I_IL2  = {5'b01101, 14'h3FFF};
  localparam logic [18:0] I_HLT  = {5'b11111, 14'h0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b0;
    instr = I_ST;
    Flag  = 4'hF;

    // Table: FETCH, EXEC, [MEM/WB] expected words per instruction
    tbl.push_back(mkv("add",   I_ADD, 4'b0010, 3, fq(0), al(5'd0)|fq(0), M_PE|M_WE|al(5'd0)|fq(4'h2), 0));
    tbl.push_back(mkv("mul",   I_MUL, 4'b1000, 3, fq(2), al(5'd2)|fq(2), M_PE|M_WE|al(5'd2)|fq(4'h8), 0));
    tbl.push_back(mkv("cmp_z", I_CMP, 4'b0001, 2, fq(8), M_PE|al(5'd1)|fq(8), 0, 0));
    tbl.push_back(mkv("beq_t", I_BEQ, 4'b0000, 2, fq(1), M_PE|M_PS|fq(1), 0, 0));
    tbl.push_back(mkv("bne_n", I_BNE, 4'b0000, 2, fq(1), M_PE|fq(1), 0, 0));
    tbl.push_back(mkv("cmp_0", I_CMP, 4'b0000, 2, fq(1), M_PE|al(5'd1)|fq(1), 0, 0));
    tbl.push_back(mkv("beq_n", I_BEQ, 4'b0001, 2, fq(0), M_PE|fq(0), 0, 0));
    tbl.push_back(mkv("bne_t", I_BNE, 4'b0001, 2, fq(0), M_PE|M_PS|fq(0), 0, 0));
    tbl.push_back(mkv("jmp",   I_JMP, 4'b1111, 2, fq(0), M_PE|M_PS|M_JM|fq(0), 0, 0));
    tbl.push_back(mkv("ld",    I_LD,  4'b1111, 4, fq(0), fq(0), fq(0), M_PE|M_WE|M_DL|fq(0)));
    tbl.push_back(mkv("st",    I_ST,  4'b1111, 3, fq(0), M_SB|fq(0), M_PE|M_SB|M_MW|fq(0), 0));
    tbl.push_back(mkv("xor",   I_XOR, 4'b0101, 3, fq(0), al(5'd8)|fq(0), M_PE|M_WE|al(5'd8)|fq(4'h5), 0));
    tbl.push_back(mkv("ill1",  I_IL1, 4'b1010, 2, fq(5), M_PE|M_IL|fq(5), 0, 0));
    tbl.push_back(mkv("not",   I_NOT, 4'b0000, 3, fq(5), al(5'd9)|fq(5), M_PE|M_WE|al(5'd9)|fq(4'h0), 0));
    tbl.push_back(mkv("ill2",  I_IL2, 4'b1111, 2, fq(0), M_PE|M_IL|fq(0), 0, 0));

    // Reset held with a store opcode presented: everything quiet
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++)
      step(21'h0, "reset", c);
    checks++;
    if (flags_q !== 4'h0 || RegWE !== 1'b0 || MemWE !== 1'b0 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: got fq=%h we=%b mw=%b pe=%b expected 0 0 0 0",
               flags_q, RegWE, MemWE, pc_en);
    end
    rst = 1'b1;

    foreach (tbl[k])
      apply_vec(tbl[k]);

    // Reset during the MEM cycle of a load aborts it and clears flags
    apply_vec(mkv("cmp_6", I_CMP, 4'b0110, 2, fq(0), M_PE|al(5'd1)|fq(0), 0, 0));
    instr = I_LD;
    Flag  = 4'hF;
    step(fq(6), "ld_abort", 0);
    step(fq(6), "ld_abort", 1);
    rst = 1'b0;
    step(fq(6), "ld_abort", 2);
    step(21'h0, "ld_abort", 3);
    checks++;
    if (RegWE !== 1'b0 || flags_q !== 4'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL ld_abort_state: got we=%b fq=%h ha=%b expected 0 0 0",
               RegWE, flags_q, halted);
    end
    rst = 1'b1;
    step(21'h0, "ld_after", 0);
    step(21'h0, "ld_after", 1);
    step(21'h0, "ld_after", 2);
    step(M_PE|M_WE|M_DL, "ld_after", 3);

    // Halt is absorbing regardless of instr/Flag activity
    instr = I_HLT;
    Flag  = 4'h0;
    step(21'h0, "hlt", 0);
    instr = I_ADD;
    for (int c = 1; c <= 20; c++) begin
      Flag = 4'($urandom_range(0, 15));
      step(M_HA, "hlt", c);
    end
    checks++;
    if (halted !== 1'b1 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL hlt_hold: got ha=%b pe=%b expected 1 0", halted, pc_en);
    end
    rst = 1'b0;
    step(M_HA, "hlt_rst", 0);
    rst = 1'b1;
    step(21'h0, "hlt_rst", 1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
